// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a one-word skid buffer,
// synchronous flush with bubble insertion and a saturating bubble counter.
module pipe_skid_reg #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_FIELDS = 3,
  parameter logic [DATA_W-1:0] PC_RESET   = 32'h0000_3000,
  parameter logic [DATA_W-1:0] NOP_INSTR  = 32'h0000_0000,
  parameter int                CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic                         in_check,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [DATA_W-1:0]            out_pc,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic                         out_check,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int DW = NUM_FIELDS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              m_valid_r, m_valid_s;
  logic [DATA_W-1:0] m_instr_r, m_instr_s;
  logic [DATA_W-1:0] m_pc_r, m_pc_s;
  logic [DW-1:0]     m_data_r, m_data_s;
  logic              m_check_r, m_check_s;
  logic              s_valid_r, s_valid_s;
  logic [DATA_W-1:0] s_instr_r, s_instr_s;
  logic [DATA_W-1:0] s_pc_r, s_pc_s;
  logic [DW-1:0]     s_data_r, s_data_s;
  logic              s_check_r, s_check_s;
  logic              in_ready_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic              accept_s, consume_s;

  assign accept_s  = in_valid && in_ready_r;
  assign consume_s = m_valid_r && out_ready;

  // Next-state of main and skid registers; an emptied main register is reloaded with bubble values.
  always_comb begin
    m_valid_s = m_valid_r;
    m_instr_s = m_instr_r;
    m_pc_s    = m_pc_r;
    m_data_s  = m_data_r;
    m_check_s = m_check_r;
    s_valid_s = s_valid_r;
    s_instr_s = s_instr_r;
    s_pc_s    = s_pc_r;
    s_data_s  = s_data_r;
    s_check_s = s_check_r;
    if (flush) begin
      m_valid_s = 1'b0;
      m_instr_s = NOP_INSTR;
      m_pc_s    = PC_RESET;
      m_data_s  = {DW{1'b0}};
      m_check_s = 1'b0;
      s_valid_s = 1'b0;
    end else if (m_valid_r && consume_s && s_valid_r) begin
      m_instr_s = s_instr_r;
      m_pc_s    = s_pc_r;
      m_data_s  = s_data_r;
      m_check_s = s_check_r;
      s_valid_s = 1'b0;
    end else if ((!m_valid_r || consume_s) && accept_s) begin
      m_valid_s = 1'b1;
      m_instr_s = in_instr;
      m_pc_s    = in_pc;
      m_data_s  = in_data;
      m_check_s = in_check;
    end else if (!m_valid_r || consume_s) begin
      m_valid_s = 1'b0;
      m_instr_s = NOP_INSTR;
      m_pc_s    = PC_RESET;
      m_data_s  = {DW{1'b0}};
      m_check_s = 1'b0;
    end else if (accept_s) begin
      // Main is stalled and skid is empty (otherwise in_ready would be low).
      s_valid_s = 1'b1;
      s_instr_s = in_instr;
      s_pc_s    = in_pc;
      s_data_s  = in_data;
      s_check_s = in_check;
    end else begin
      m_valid_s = m_valid_r;
    end
  end

  // State registers; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r  <= 1'b0;
      m_instr_r  <= NOP_INSTR;
      m_pc_r     <= PC_RESET;
      m_data_r   <= {DW{1'b0}};
      m_check_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      s_instr_r  <= NOP_INSTR;
      s_pc_r     <= PC_RESET;
      s_data_r   <= {DW{1'b0}};
      s_check_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      m_valid_r  <= m_valid_s;
      m_instr_r  <= m_instr_s;
      m_pc_r     <= m_pc_s;
      m_data_r   <= m_data_s;
      m_check_r  <= m_check_s;
      s_valid_r  <= s_valid_s;
      s_instr_r  <= s_instr_s;
      s_pc_r     <= s_pc_s;
      s_data_r   <= s_data_s;
      s_check_r  <= s_check_s;
      in_ready_r <= !s_valid_s;
    end
  end

  // Saturating count of edges that saw an empty output; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!m_valid_r && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = m_valid_r;
  assign out_instr  = m_instr_r;
  assign out_pc     = m_pc_r;
  assign out_data   = m_data_r;
  assign out_check  = m_check_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule
